// File: rtl/apu_dac_mix_if.sv
// Sample-set handshake between the APU sample source and apu_dac_mix.
// The source drives channel enables, packed samples and valid; the DAC returns ready.
interface apu_dac_mix_if #(
  parameter int N  = 8,
  parameter int CH = 4
);
  logic [CH-1:0]   ch_en;
  logic [CH*N-1:0] smp;
  logic            smp_valid;
  logic            smp_ready;

  modport master (output ch_en, output smp, output smp_valid, input smp_ready);
  modport slave  (input ch_en, input smp, input smp_valid, output smp_ready);
endinterface

// File: rtl/apu_dac_mix.sv
// Multi-channel audio DAC: mixes enabled channel samples and drives a 1-bit PWM output.
// Define APU_DAC_DSM_EN to add a first-order sigma-delta mode selected by the mode input.
module apu_dac_mix #(
  parameter int N  = 8,
  parameter int CH = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         en,
  input  logic         mode,
  apu_dac_mix_if.slave bus,
  output logic         q,
  output logic         tick
);
  localparam int W = N + $clog2(CH);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_W  = {W{1'b0}};

  // W bits hold CH full-scale samples without overflow.
  function automatic logic [W-1:0] mix_sum(input logic [CH*N-1:0] s, input logic [CH-1:0] e);
    logic [W-1:0] total;
    total = ZERO_W;
    for (int k = 0; k < CH; k++) begin
      if (e[k]) total = total + W'(s[k*N +: N]);
      else      total = total;
    end
    return total;
  endfunction

  logic [W-1:0] cnt_r, level_r, pending_r;
  logic         pending_full_r, q_r, tick_r;
  logic [W-1:0] cnt_next_s, level_next_s, pending_next_s;
  logic         accept_s, wrap_s, load_s, pending_full_next_s;
  logic         pwm_q_s, q_next_s, dsm_s;

  // Handshake, period counter, level transfer and PWM compare.
  always_comb begin
    accept_s   = bus.smp_valid & ~pending_full_r;
    wrap_s     = en & (cnt_r == CNT_MAX);
    cnt_next_s = en ? (cnt_r + CNT_ONE) : cnt_r;
    if (dsm_s) load_s = en & pending_full_r;
    else       load_s = wrap_s & pending_full_r;
    level_next_s   = load_s ? pending_r : level_r;
    pending_next_s = accept_s ? mix_sum(bus.smp, bus.ch_en) : pending_r;
    if (accept_s)    pending_full_next_s = 1'b1;
    else if (load_s) pending_full_next_s = 1'b0;
    else             pending_full_next_s = pending_full_r;
    // Compare against next-state values so q lines up with the registered counter.
    pwm_q_s = en & (cnt_next_s < level_next_s);
  end

`ifdef APU_DAC_DSM_EN
  logic [W-1:0] acc_r, acc_next_s;
  logic [W:0]   sum_s;
  logic         mode_r, mode_chg_s;

  assign dsm_s = mode_r;

  // Sigma-delta accumulator; a mode switch restarts it from zero.
  always_comb begin
    mode_chg_s = mode ^ mode_r;
    sum_s      = {1'b0, acc_r} + {1'b0, level_r};
    if (mode_chg_s) begin
      acc_next_s = ZERO_W;
      q_next_s   = 1'b0;
    end else if (dsm_s) begin
      if (en) begin
        acc_next_s = sum_s[W-1:0];
        q_next_s   = sum_s[W];
      end else begin
        acc_next_s = acc_r;
        q_next_s   = 1'b0;
      end
    end else begin
      acc_next_s = acc_r;
      q_next_s   = pwm_q_s;
    end
  end

  // Accumulator and applied-mode registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_r  <= ZERO_W;
      mode_r <= 1'b0;
    end else begin
      acc_r  <= acc_next_s;
      mode_r <= mode;
    end
  end
`else
  logic mode_unused_s;

  assign mode_unused_s = mode;
  assign dsm_s         = 1'b0;
  assign q_next_s      = pwm_q_s;
`endif

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r          <= ZERO_W;
      level_r        <= ZERO_W;
      pending_r      <= ZERO_W;
      pending_full_r <= 1'b0;
      q_r            <= 1'b0;
      tick_r         <= 1'b0;
    end else begin
      cnt_r          <= cnt_next_s;
      level_r        <= level_next_s;
      pending_r      <= pending_next_s;
      pending_full_r <= pending_full_next_s;
      q_r            <= q_next_s;
      tick_r         <= wrap_s;
    end
  end

  assign bus.smp_ready = ~pending_full_r;
  assign q             = q_r;
  assign tick          = tick_r;
endmodule

// File: tb/tb_apu_dac_mix.sv
// Self-checking bench for apu_dac_mix (N=8, CH=2, period 512) against a period-position model.
module tb_apu_dac_mix;
  logic clk = 1'b0;
  logic n_reset = 1'b1;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic q, tick;

  apu_dac_mix_if #(.N(8), .CH(2)) bus ();

  apu_dac_mix #(.N(8), .CH(2)) dut (
    .clk(clk), .n_reset(n_reset), .en(en), .mode(mode), .bus(bus), .q(q), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cnt, m_level, m_pending;
  bit m_full, m_q, m_tick;
  bit chk_q = 1'b1;
  int ones, n, exp_lvl;
  logic [7:0] ra, rb;
  logic [1:0] rce;
  logic prev_q;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_level = 0; m_pending = 0; m_full = 1'b0; m_q = 1'b0; m_tick = 1'b0;
  endtask

  // One clock: q is high while the period position is below the level.
  task automatic step();
    logic v, e;
    bit acc;
    int sum;
`ifndef APU_DAC_DSM_EN
    mode = 1'($urandom_range(0, 1));
`endif
    v   = bus.smp_valid;
    e   = en;
    sum = (bus.ch_en[0] ? int'(bus.smp[7:0]) : 0) + (bus.ch_en[1] ? int'(bus.smp[15:8]) : 0);
    acc = v && !m_full;
    @(posedge clk);
    m_tick = e && (m_cnt == 511);
    if (m_tick && m_full) begin
      m_level = m_pending;
      m_full  = 1'b0;
    end
    if (acc) begin
      m_pending = sum;
      m_full    = 1'b1;
    end
    if (e) m_cnt = (m_cnt + 1) % 512;
    m_q = e && (m_cnt < m_level);
    #1;
    chk_bit("tick", tick, m_tick);
    chk_bit("smp_ready", bus.smp_ready, !m_full);
    if (chk_q) chk_bit("q", q, m_q);
  endtask

  task automatic send(input logic [1:0] ce, input logic [7:0] a, input logic [7:0] b);
    bus.ch_en = ce;
    bus.smp = {b, a};
    bus.smp_valid = 1'b1;
    step();
    bus.smp_valid = 1'b0;
    bus.smp = 16'($urandom);
  endtask

  task automatic wait_wrap();
    int k = 0;
    do begin
      step();
      k++;
    end while (tick !== 1'b1 && k < 1100);
    chk_bit("wrap_reached", tick, 1'b1);
  endtask

  // Call right after a tick (position 0): counts q ones over the whole period.
  task automatic count_period(output int cnt1);
    cnt1 = int'(q);
    repeat (511) begin
      step();
      cnt1 += int'(q);
    end
  endtask

  initial begin
    bus.ch_en = 2'b00;
    bus.smp = 16'h0000;
    bus.smp_valid = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    chk_bit("reset_q", q, 1'b0);
    chk_bit("reset_tick", tick, 1'b0);
    chk_bit("reset_ready", bus.smp_ready, 1'b1);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    en = 1'b1;
    model_reset();

    send(2'b11, 8'h80, 8'h00);
    chk_bit("ready_low_after_accept", bus.smp_ready, 1'b0);
    wait_wrap();
    count_period(ones);
    chk_int("level_128", ones, 128);

    send(2'b11, 8'hFF, 8'hFF);
    wait_wrap();
    count_period(ones);
    chk_int("level_510", ones, 510);

    send(2'b01, 8'h40, 8'hFF);
    bus.ch_en = 2'b10;
    wait_wrap();
    count_period(ones);
    chk_int("level_64_ch0_only", ones, 64);

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rce = 2'($urandom_range(0, 3));
      exp_lvl = (rce[0] ? int'(ra) : 0) + (rce[1] ? int'(rb) : 0);
      send(rce, ra, rb);
      bus.ch_en = ~rce;
      wait_wrap();
      count_period(ones);
      chk_int("level_random", ones, exp_lvl);
    end

    // Second sample held while the buffer is full.
    bus.ch_en = 2'b11;
    bus.smp = {8'h10, 8'h20};
    bus.smp_valid = 1'b1;
    step();
    bus.smp = {8'h30, 8'h10};
    wait_wrap();
    ones = int'(q);
    step();
    ones += int'(q);
    bus.smp_valid = 1'b0;
    chk_bit("held_accepted", bus.smp_ready, 1'b0);
    repeat (510) begin
      step();
      ones += int'(q);
    end
    chk_int("held_first_level", ones, 48);
    wait_wrap();
    count_period(ones);
    chk_int("held_second_level", ones, 64);

    // Output enable dropped for 100 cycles mid-period.
    wait_wrap();
    n = 0;
    ones = int'(q);
    repeat (200) begin
      step();
      n++;
      ones += int'(q);
    end
    en = 1'b0;
    repeat (100) begin
      step();
      n++;
      ones += int'(q);
    end
    en = 1'b1;
    do begin
      step();
      n++;
      if (tick !== 1'b1) ones += int'(q);
    end while (tick !== 1'b1 && n < 2000);
    chk_int("frozen_period_len", n, 612);
    chk_int("frozen_period_ones", ones, 64);

    // Asynchronous reset mid-period with a sample pending.
    send(2'b11, 8'h55, 8'h55);
    repeat (10) step();
    chk_bit("q_before_reset", q, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    chk_bit("midrun_reset_q", q, 1'b0);
    chk_bit("midrun_reset_tick", tick, 1'b0);
    chk_bit("midrun_reset_ready", bus.smp_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    n = 0;
    ones = 0;
    do begin
      step();
      n++;
      ones += int'(q);
    end while (tick !== 1'b1 && n < 2000);
    chk_int("post_reset_period", n, 512);
    chk_int("post_reset_ones", ones, 0);
    count_period(ones);
    chk_int("pending_discarded", ones, 0);

`ifdef APU_DAC_DSM_EN
    send(2'b11, 8'h80, 8'h80);
    wait_wrap();
    chk_q = 1'b0;
    mode = 1'b1;
    step();
    chk_bit("dsm_enter_q", q, 1'b0);
    ones = 0;
    prev_q = q;
    for (int i = 1; i <= 513; i++) begin
      step();
      ones += int'(q);
      if (i > 1) chk_bit("dsm_alternate", q, ~prev_q);
      prev_q = q;
    end
    chk_int("dsm_ones_256", ones, 256);
    mode = 1'b0;
    step();
    chk_bit("dsm_exit_q", q, 1'b0);
    mode = 1'b1;
    step();
    chk_bit("dsm_reenter_q", q, 1'b0);
    step();
    chk_bit("dsm_acc_cleared", q, 1'b0);
    step();
    chk_bit("dsm_first_one", q, 1'b1);
    mode = 1'b0;
    step();
    step();
    chk_q = 1'b1;
    wait_wrap();
    count_period(ones);
    chk_int("pwm_after_dsm", ones, 256);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
